// File: rtl/alu_flag_stage.sv
// Registered result/flag stage behind the ripple adder: computes C,S,Z,P,OF,
// buffers results in a small FIFO and counts delivered overflowing results.
module alu_flag_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [4:0]       out_flags,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam int             FLAG_OF  = 0;

    logic [WIDTH-1:0] sum_mem  [DEPTH];
    logic [4:0]       flag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic       push;
    logic       pop;
    logic       a_neg;
    logic       b_neg;
    logic       s_neg;
    logic [4:0] flags_in;

    assign in_ready  = !rst && (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Sign tests on the full operands; these reduce to the MSBs.
    assign a_neg = $signed(in_a)   < $signed({WIDTH{1'b0}});
    assign b_neg = $signed(in_b)   < $signed({WIDTH{1'b0}});
    assign s_neg = $signed(in_sum) < $signed({WIDTH{1'b0}});

    // {C, S, Z, P(even), OF}
    assign flags_in = {in_cout,
                       s_neg,
                       (in_sum == '0),
                       ~^in_sum,
                       (a_neg == b_neg) && (s_neg != a_neg)};

    assign out_sum   = out_valid ? sum_mem[rd_ptr]  : '0;
    assign out_flags = out_valid ? flag_mem[rd_ptr] : '0;

    // NOTE: storage is not reset; entries are only observable through out_valid,
    // and the zero-gating above hides stale contents after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sum_mem[wr_ptr]  <= in_sum;
            flag_mem[wr_ptr] <= flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (pop && flag_mem[rd_ptr][FLAG_OF] && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed, table-driven bench for alu_flag_stage plus hand-written
// back-pressure, saturation, clear-priority and mid-operation reset sequences.
module tb_alu_flag_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [4:0]  out_flags;
    logic [7:0]  ovf_cnt;
    logic        ovf_clr;

    int checks;
    int errors;

    alu_flag_stage #(.WIDTH(16), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .ovf_cnt   (ovf_cnt),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic [4:0]  flags;   // {C,S,Z,P,OF}
        logic [7:0]  ovf;     // ovf_cnt after this entry is popped
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic c);
        in_a    = a;
        in_b    = b;
        in_sum  = s;
        in_cout = c;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000, 1'b0);

        vecs[0] = '{16'h0001, 16'h0001, 16'h0002, 1'b0, 5'b00000, 8'd0};
        vecs[1] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1, 5'b10110, 8'd0};
        vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 5'b10111, 8'd1};
        vecs[3] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 5'b01001, 8'd2};
        vecs[4] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 5'b00010, 8'd2};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 5'b11000, 8'd2};

        // Reset state
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Single push / pop per vector
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_sum", i), out_sum, vecs[i].sum);
            check($sformatf("v%0d_flags", i), out_flags, vecs[i].flags);
            step();
            check($sformatf("v%0d_empty_valid", i), out_valid, 0);
            check($sformatf("v%0d_empty_sum", i), out_sum, 0);
            check($sformatf("v%0d_empty_flags", i), out_flags, 0);
            check($sformatf("v%0d_ovf", i), ovf_cnt, vecs[i].ovf);
        end

        // Back-pressure: third entry held upstream until a slot frees
        out_ready = 1'b0;
        drive(16'h0001, 16'h0001, 16'h0002, 1'b0);
        in_valid = 1'b1;
        step();
        check("bp_ready_after1", in_ready, 1);
        drive(16'h0001, 16'hFFFF, 16'h0000, 1'b1);
        step();
        check("bp_ready_after2", in_ready, 0);
        drive(16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        step();
        check("bp_held_ready", in_ready, 0);
        check("bp_stable_sum", out_sum, 16'h0002);
        check("bp_stable_flags", out_flags, 5'b00000);
        out_ready = 1'b1;
        step();
        check("bp_pop1_sum", out_sum, 16'h0000);
        check("bp_pop1_flags", out_flags, 5'b10110);
        check("bp_pop1_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_pop2_sum", out_sum, 16'h8000);
        check("bp_pop2_flags", out_flags, 5'b01001);
        check("bp_pop2_ovf", ovf_cnt, 2);
        step();
        check("bp_done_valid", out_valid, 0);
        check("bp_done_ovf", ovf_cnt, 3);

        // Clear without a pop
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", ovf_cnt, 0);

        // Stream 260 overflowing results: counter saturates, no wrap
        drive(16'h8000, 16'h8000, 16'h0000, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_valid", out_valid, 0);
        check("sat_ovf", ovf_cnt, 8'hFF);

        // Clear wins over a same-cycle overflowing pop
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("prio_pre_ovf", ovf_cnt, 8'hFF);
        check("prio_pre_valid", out_valid, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("prio_ovf", ovf_cnt, 0);
        check("prio_valid", out_valid, 0);

        // Mid-operation reset with a full buffer and a pending pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("mrst_full_ready", in_ready, 0);
        check("mrst_full_valid", out_valid, 1);
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check("mrst_in_ready_low", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_sum", out_sum, 0);
        check("mrst_ovf", ovf_cnt, 0);
        check("mrst_ready", in_ready, 1);
        step();
        check("mrst_still_empty", out_valid, 0);
        check("mrst_ovf_after", ovf_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
